// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: two-requester read arbiter in front of an Avalon-MM flash, with a readdatavalid timeout.
// Define ROUND_ROBIN_EN for round-robin arbitration; the default build gives requester A fixed priority.
module flash_read_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_done,
    output logic [31:0]       a_data,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_done,
    output logic [31:0]       b_data,
    output logic              err,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAITDATA = 2'd2, RESPOND = 2'd3;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0]        r_state;
    logic              r_grant_b;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_cnt;
    logic [31:0]       r_a_data;
    logic [31:0]       r_b_data;
    logic              w_pick_b;
    logic              w_finish;
    logic [31:0]       w_word;
`ifdef ROUND_ROBIN_EN
    logic r_last_b;
    assign w_pick_b = b_req && (!a_req || !r_last_b);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last_b <= 1'b1;
        else if (r_state == IDLE && (a_req || b_req))
            r_last_b <= w_pick_b;
    end
`else
    assign w_pick_b = b_req && !a_req;
`endif
    // A response arriving on the final WAITDATA cycle still wins over the timeout.
    assign w_finish = flash_mem_readdatavalid || (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_word   = flash_mem_readdatavalid ? flash_mem_readdata : 32'h0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant_b <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_a_data  <= '0;
            r_b_data  <= '0;
        end else begin
            case (r_state)
                IDLE: if (a_req || b_req) begin
                    r_grant_b <= w_pick_b;
                    r_addr    <= w_pick_b ? b_addr : a_addr;
                    r_err     <= 1'b0;
                    r_state   <= ISSUE;
                end
                ISSUE: if (!flash_mem_waitrequest) begin
                    r_cnt   <= '0;
                    r_state <= WAITDATA;
                end
                WAITDATA: if (w_finish) begin
                    if (r_grant_b)
                        r_b_data <= w_word;
                    else
                        r_a_data <= w_word;
                    r_err   <= !flash_mem_readdatavalid;
                    r_state <= RESPOND;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign flash_mem_read       = r_state == ISSUE;
    assign flash_mem_address    = r_addr;
    assign flash_mem_byteenable = 4'hF;
    assign a_done               = r_state == RESPOND && !r_grant_b;
    assign b_done               = r_state == RESPOND && r_grant_b;
    assign err                  = r_state == RESPOND && r_err;
    assign a_data               = r_a_data;
    assign b_data               = r_b_data;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: randomized self-checking bench for flash_read_arbiter.
// A behavioural flash responder plus a transaction-level model supply every expected value.
module tb_flash_read_arbiter;
    localparam int AW = 23;
    localparam int TO = 12;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0;
    logic          b_req = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [AW-1:0] b_addr = '0;
    logic          a_done, b_done, err, flash_mem_read;
    logic [31:0]   a_data, b_data;
    logic [AW-1:0] flash_mem_address;
    logic [3:0]    flash_mem_byteenable;
    logic          flash_mem_waitrequest = 1'b0;
    logic [31:0]   flash_mem_readdata = '0;
    logic          flash_mem_readdatavalid = 1'b0;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   m_a = '0;
    logic [31:0]   m_b = '0;
    bit            m_last_b = 1'b1;

    int            fl_wait = 0;
    int            fl_lat = 1;
    logic [31:0]   fl_word = '0;
    int            pend = 0;
    int            wcnt = 0;
    int            rd_cycles = 0;
    logic [AW-1:0] acc_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    bit            rd_addr_bad = 1'b0;

    always #5 clk = ~clk;

    flash_read_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_done(a_done), .a_data(a_data),
        .b_req(b_req), .b_addr(b_addr), .b_done(b_done), .b_data(b_data),
        .err(err),
        .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
        .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid)
    );

    // Flash: stalls fl_wait cycles, answers fl_lat cycles after accept (0 = never).
    always @(negedge clk) begin
        flash_mem_readdatavalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata = fl_word;
            end
        end
        if (flash_mem_read) begin
            if (rd_cycles == 0) rd_addr = flash_mem_address;
            else if (flash_mem_address !== rd_addr) rd_addr_bad = 1'b1;
            rd_cycles++;
            if (wcnt < fl_wait) begin
                flash_mem_waitrequest = 1'b1;
                wcnt++;
            end else begin
                flash_mem_waitrequest = 1'b0;
                wcnt = 0;
                acc_addr = flash_mem_address;
                pend = fl_lat;
            end
        end else begin
            flash_mem_waitrequest = 1'b0;
            wcnt = 0;
        end
    end

    task automatic do_txn(input bit is_b, input logic [AW-1:0] addr, input int wt, input int lat,
                          input logic [31:0] word, input bit scramble);
        int n;
        int exp_n;
        bit seen;
        bit exp_err;
        logic [31:0] exp_d;
        exp_err = (lat == 0) || (lat > TO);
        exp_n = exp_err ? wt + TO + 2 : wt + lat + 2;
        exp_d = exp_err ? 32'h0 : word;
        fl_wait = wt; fl_lat = lat; fl_word = word; rd_cycles = 0; rd_addr_bad = 1'b0;
        if (is_b) begin b_addr = addr; b_req = 1'b1; end
        else begin a_addr = addr; a_req = 1'b1; end
        seen = 1'b0;
        n = 0;
        while (!seen && n < exp_n + 8) begin
            @(negedge clk);
            n++;
            if (scramble) begin
                if (is_b) b_addr = AW'($urandom);
                else a_addr = AW'($urandom);
            end
            seen = a_done || b_done;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL txn_no_done: no done after %0d cycles, wanted one at cycle %0d", n, exp_n);
        end else begin
            n_cmp++;
            if (n != exp_n) begin n_bad++; $display("FAIL done_latency: got %0d want %0d", n, exp_n); end
            n_cmp++;
            if ({a_done, b_done} !== {!is_b, is_b}) begin n_bad++; $display("FAIL done_target: got a=%b b=%b want b=%b", a_done, b_done, is_b); end
            n_cmp++;
            if (err !== exp_err) begin n_bad++; $display("FAIL err_flag: got %b want %b", err, exp_err); end
            n_cmp++;
            if ((is_b ? b_data : a_data) !== exp_d) begin n_bad++; $display("FAIL own_data: got %h want %h", is_b ? b_data : a_data, exp_d); end
            n_cmp++;
            if ((is_b ? a_data : b_data) !== (is_b ? m_a : m_b)) begin n_bad++; $display("FAIL other_data: got %h want %h", is_b ? a_data : b_data, is_b ? m_a : m_b); end
            n_cmp++;
            if (acc_addr !== addr) begin n_bad++; $display("FAIL flash_addr: got %h want %h", acc_addr, addr); end
            n_cmp++;
            if (rd_cycles != wt + 1 || rd_addr_bad) begin n_bad++; $display("FAIL read_strobe: got %0d cycles (addr_moved=%b) want %0d stable", rd_cycles, rd_addr_bad, wt + 1); end
            if (is_b) m_b = exp_d; else m_a = exp_d;
            m_last_b = is_b;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_done, b_done, err} !== 3'b000) begin n_bad++; $display("FAIL done_pulse: got a=%b b=%b err=%b want 000", a_done, b_done, err); end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({a_done, b_done, err, flash_mem_read} !== 4'b0 || flash_mem_address !== '0 || a_data !== '0 || b_data !== '0) begin
            n_bad++;
            $display("FAIL %s: got done=%b%b err=%b read=%b addr=%h a=%h b=%h want all zero", name,
                     a_done, b_done, err, flash_mem_read, flash_mem_address, a_data, b_data);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        n_cmp++;
        if (flash_mem_byteenable !== 4'hF) begin n_bad++; $display("FAIL byteenable: got %h want f", flash_mem_byteenable); end
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle_after_reset");
    endtask

    task automatic test_basic;
        do_txn(1'b0, 23'h000100, 0, 1, 32'hAABBCCDD, 1'b0);
    endtask

    task automatic test_waitrequest;
        do_txn(1'b1, AW'($urandom), 5, 1, 32'h11223344, 1'b0);
    endtask

    task automatic test_arbitration;
        bit exp_b;
        int n;
        logic [AW-1:0] aa, bb;
        aa = AW'($urandom); bb = AW'($urandom);
        fl_wait = 0; fl_lat = 1; fl_word = $urandom;
        a_addr = aa; b_addr = bb; a_req = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_b = !a_req || (RR && !m_last_b);
            n = 0;
            do begin @(negedge clk); n++; end while (!(a_done || b_done) && n < 20);
            n_cmp++;
            if ({a_done, b_done} !== {!exp_b, exp_b}) begin n_bad++; $display("FAIL arb_grant[%0d]: got a=%b b=%b want b=%b", k, a_done, b_done, exp_b); end
            n_cmp++;
            if ((exp_b ? b_data : a_data) !== fl_word) begin n_bad++; $display("FAIL arb_data[%0d]: got %h want %h", k, exp_b ? b_data : a_data, fl_word); end
            n_cmp++;
            if (acc_addr !== (exp_b ? bb : aa)) begin n_bad++; $display("FAIL arb_addr[%0d]: got %h want %h", k, acc_addr, exp_b ? bb : aa); end
            if (exp_b) m_b = fl_word; else m_a = fl_word;
            m_last_b = exp_b;
            n_cmp++;
            if ((exp_b ? a_data : b_data) !== (exp_b ? m_a : m_b)) begin n_bad++; $display("FAIL arb_other[%0d]: got %h want %h", k, exp_b ? a_data : b_data, exp_b ? m_a : m_b); end
            fl_word = $urandom;
            if (k == 3) a_req = 1'b0;
            if (k == 4) b_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        do_txn(1'b0, AW'($urandom), 1, 0, $urandom, 1'b0);
        do_txn(1'b1, AW'($urandom), 0, TO, $urandom, 1'b0);
        do_txn(1'b0, AW'($urandom), 0, TO + 1, $urandom, 1'b0);
        do_txn(1'b0, AW'($urandom), 0, 2, $urandom, 1'b0);
    endtask

    task automatic test_reset_mid;
        a_addr = AW'($urandom); a_req = 1'b1;
        fl_wait = 0; fl_lat = 4; fl_word = $urandom;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        a_req = 1'b0;
        #1;
        check_zero("reset_mid_txn");
        @(negedge clk);
        reset = 1'b0;
        m_a = '0; m_b = '0; m_last_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_zero("no_done_after_reset");
        end
        do_txn(1'b0, AW'($urandom), 0, 1, $urandom, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++)
            do_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom_range(0, 3), $urandom_range(1, 4), $urandom, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_waitrequest;
        test_arbitration;
        test_timeout;
        test_reset_mid;
        test_random;
        test_arbitration;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
